// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifetch_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2
  } ifetch_state_t;

  localparam logic       CMD_RD    = 1'b0;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Buffer entry layout at the default 32-bit address/data widths.
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } ifetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with flush, occupancy count and a combinational head (zero when empty).
module ifetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // Flush wins over both ports; a push into a full buffer is only legal alongside a pop.
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: issues sequential word reads, buffers responses with
// their PCs for decode, flushes on redirect and halts after an error response.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int                     p_ADDR_BITS  = 32,
  parameter int                     p_DATA_BITS  = 32,
  parameter logic [p_ADDR_BITS-1:0] p_RESET_PC   = '0,
  parameter int                     p_FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [p_ADDR_BITS-1:0] redirect_pc,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [p_DATA_BITS-1:0] inst_data,
  output logic [p_ADDR_BITS-1:0] inst_pc,
  output logic                   inst_err,
  output logic [p_ADDR_BITS-1:0] imem_addr,
  output logic                   imem_cmd,
  output logic [1:0]             imem_size,
  output logic                   imem_valid,
  input  logic                   imem_ready,
  input  logic                   imem_r_valid,
  output logic                   imem_r_ready,
  input  logic [p_DATA_BITS-1:0] imem_r_data,
  input  logic                   imem_r_resp,
  output ifetch_state_t          dbg_state
);

  localparam int CW = $clog2(p_FIFO_DEPTH) + 1;
  localparam int EW = p_DATA_BITS + p_ADDR_BITS + 1;

  ifetch_state_t          state;
  ifetch_state_t          state_nxt;
  logic [p_ADDR_BITS-1:0] pc;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          inflight_nxt;
  logic [CW-1:0]          drop_cnt;
  logic [CW-1:0]          ibuf_count;
  logic [CW-1:0]          pcq_count;
  logic [EW-1:0]          ibuf_head;
  logic [p_ADDR_BITS-1:0] resp_pc;
  logic                   has_credit;
  logic                   cmd_fire;
  logic                   resp_fire;
  logic                   resp_accept;
  logic                   err_push;
  logic                   inst_pop;
  logic                   redirect_lsb_unused;

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // command side holds imem_valid/imem_addr stable until it fires, and responses
  // are always accepted because credits reserve buffer space before each read.
  assign has_credit   = ({1'b0, inflight} + {1'b0, ibuf_count}) < (CW+1)'(p_FIFO_DEPTH);
  assign imem_valid   = (state == S_RUN) && !redirect_valid && has_credit;
  assign cmd_fire     = imem_valid && imem_ready;
  assign resp_fire    = imem_r_valid;
  assign resp_accept  = resp_fire && (drop_cnt == '0) && !redirect_valid;
  assign err_push     = resp_accept && imem_r_resp;
  assign inst_valid   = (ibuf_count != '0);
  assign inst_pop     = inst_valid && inst_ready;
  assign inflight_nxt = inflight + CW'(cmd_fire) - CW'(resp_fire);

  assign imem_addr    = pc;
  assign imem_cmd     = CMD_RD;
  assign imem_size    = SIZE_WORD;
  assign imem_r_ready = 1'b1;
  assign dbg_state    = state;
  assign {inst_data, inst_pc, inst_err} = ibuf_head;
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET: state_nxt = S_RUN;
      S_RUN:   if (err_push) state_nxt = S_HALT;
      S_HALT:  if (redirect_valid) state_nxt = S_RUN;
      default: state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RESET;
      pc       <= p_RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= inflight_nxt;
      if (redirect_valid)
        pc <= {redirect_pc[p_ADDR_BITS-1:2], 2'b00};
      else if (cmd_fire)
        pc <= pc + p_ADDR_BITS'(4);
      // Everything still outstanding after a redirect or an error is stale.
      if (redirect_valid || err_push)
        drop_cnt <= inflight_nxt;
      else if (resp_fire && (drop_cnt != '0))
        drop_cnt <= drop_cnt - 1'b1;
    end
  end

  // PCs of reads whose responses will be kept; stale entries are flushed by the next redirect.
  ifetch_fifo #(.W(p_ADDR_BITS), .DEPTH(p_FIFO_DEPTH)) u_pcq (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (cmd_fire),
    .push_data (pc),
    .pop       (resp_accept),
    .head      (resp_pc),
    .count     (pcq_count)
  );

  ifetch_fifo #(.W(EW), .DEPTH(p_FIFO_DEPTH)) u_ibuf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (resp_accept),
    .push_data ({imem_r_data, resp_pc, imem_r_resp}),
    .pop       (inst_pop),
    .head      (ibuf_head),
    .count     (ibuf_count)
  );

  assert property (@(posedge clk) disable iff (rst)
    !(resp_accept && (ibuf_count == CW'(p_FIFO_DEPTH)) && !inst_pop));
  assert property (@(posedge clk) disable iff (rst)
    !(resp_accept && (pcq_count == '0)));

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with an in-order memory responder (1-cycle latency, holdable).
module tb_ifetch_unit;
  import ifetch_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [31:0]   inst_data;
  logic [31:0]   inst_pc;
  logic          inst_err;
  logic [31:0]   imem_addr;
  logic          imem_cmd;
  logic [1:0]    imem_size;
  logic          imem_valid;
  logic          imem_ready = 1'b0;
  logic          imem_r_valid = 1'b0;
  logic          imem_r_ready;
  logic [31:0]   imem_r_data = '0;
  logic          imem_r_resp = 1'b0;
  ifetch_state_t dbg_state;

  int total = 0;
  int bad = 0;

  logic          resp_hold = 1'b0;
  logic          err_en = 1'b0;
  logic [31:0]   err_addr = '0;
  logic [31:0]   mem_q[$];
  logic [31:0]   cmd_log[$];
  ifetch_entry_t inst_log[$];

  ifetch_unit #(
    .p_ADDR_BITS(32), .p_DATA_BITS(32), .p_RESET_PC(32'h0000_0000), .p_FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_err(inst_err),
    .imem_addr(imem_addr), .imem_cmd(imem_cmd), .imem_size(imem_size),
    .imem_valid(imem_valid), .imem_ready(imem_ready),
    .imem_r_valid(imem_r_valid), .imem_r_ready(imem_r_ready),
    .imem_r_data(imem_r_data), .imem_r_resp(imem_r_resp),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // Memory responder: data word = address + 0x1000_0000, error flag for err_addr.
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (!rst && imem_valid && imem_ready) mem_q.push_back(imem_addr);
      @(posedge clk);
      #2;
      if (rst) begin
        mem_q.delete();
        imem_r_valid = 1'b0;
        imem_r_data  = '0;
        imem_r_resp  = 1'b0;
      end else if (!resp_hold && mem_q.size() > 0) begin
        a = mem_q.pop_front();
        imem_r_valid = 1'b1;
        imem_r_data  = a + 32'h1000_0000;
        imem_r_resp  = err_en && (a == err_addr);
      end else begin
        imem_r_valid = 1'b0;
        imem_r_data  = '0;
        imem_r_resp  = 1'b0;
      end
    end
  end

  // Monitor: log every fired command and every instruction handed to decode.
  initial begin
    ifetch_entry_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (imem_valid && imem_ready) cmd_log.push_back(imem_addr);
        if (inst_valid && inst_ready) begin
          e.data = inst_data;
          e.pc   = inst_pc;
          e.err  = inst_err;
          inst_log.push_back(e);
        end
      end
    end
  end

  function automatic logic [31:0] cmd_at(input int i);
    return (i < cmd_log.size()) ? cmd_log[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic ifetch_entry_t inst_at(input int i);
    ifetch_entry_t x;
    x = 'x;
    return (i < inst_log.size()) ? inst_log[i] : x;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;
    imem_ready = 1'b0;
    resp_hold = 1'b0;
    err_en = 1'b0;
    tick(2);
    rst = 1'b0;
    cmd_log.delete();
    inst_log.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    @(negedge clk);
    total++; if (dbg_state !== S_RESET) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, S_RESET); end
    total++; if (imem_valid !== 1'b0) begin bad++; $display("FAIL rst_imem_valid got=%b exp=0", imem_valid); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
    total++; if (inst_err !== 1'b0) begin bad++; $display("FAIL rst_inst_err got=%b exp=0", inst_err); end
    total++; if (inst_data !== 32'h0) begin bad++; $display("FAIL rst_inst_data got=%h exp=0", inst_data); end
    total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL rst_inst_pc got=%h exp=0", inst_pc); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_imem_addr got=%h exp=0", imem_addr); end
    total++; if (imem_cmd !== 1'b0) begin bad++; $display("FAIL rst_imem_cmd got=%b exp=0", imem_cmd); end
    total++; if (imem_size !== 2'b10) begin bad++; $display("FAIL rst_imem_size got=%b exp=10", imem_size); end
    total++; if (imem_r_ready !== 1'b1) begin bad++; $display("FAIL rst_r_ready got=%b exp=1", imem_r_ready); end
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    total++; if (imem_valid !== 1'b0) begin bad++; $display("FAIL rel_cycle1_valid got=%b exp=0", imem_valid); end
    @(negedge clk);
    total++; if (imem_valid !== 1'b1) begin bad++; $display("FAIL rel_cycle2_valid got=%b exp=1", imem_valid); end
    total++; if (dbg_state !== S_RUN) begin bad++; $display("FAIL rel_state got=%0d exp=%0d", dbg_state, S_RUN); end
  endtask

  task automatic test_sequential();
    apply_reset();
    imem_ready = 1'b1;
    inst_ready = 1'b1;
    tick(3);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=1", k, inst_valid); end
      total++; if (inst_pc !== 32'(4 * k)) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", k, inst_pc, 32'(4 * k)); end
      total++; if (inst_data !== 32'h1000_0000 + 32'(4 * k)) begin bad++; $display("FAIL seq_data[%0d] got=%h exp=%h", k, inst_data, 32'h1000_0000 + 32'(4 * k)); end
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (cmd_at(i) !== 32'(4 * i)) begin bad++; $display("FAIL seq_cmd[%0d] got=%h exp=%h", i, cmd_at(i), 32'(4 * i)); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    imem_ready = 1'b1;
    inst_ready = 1'b0;
    tick(12);
    @(negedge clk);
    total++; if (cmd_log.size() !== 4) begin bad++; $display("FAIL bp_cmd_count got=%0d exp=4", cmd_log.size()); end
    total++; if (cmd_at(3) !== 32'hC) begin bad++; $display("FAIL bp_cmd3 got=%h exp=c", cmd_at(3)); end
    total++; if (imem_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_stall got=%b exp=0", imem_valid); end
    total++; if (inst_pc !== 32'h0 || inst_valid !== 1'b1) begin bad++; $display("FAIL bp_head got=%b/%h exp=1/0", inst_valid, inst_pc); end
    tick(1);
    cmd_log.delete();
    inst_ready = 1'b1;
    tick(8);
    total++; if (cmd_at(0) !== 32'h10) begin bad++; $display("FAIL bp_resume_cmd got=%h exp=10", cmd_at(0)); end
    total++; if (inst_at(0).pc !== 32'h0) begin bad++; $display("FAIL bp_inst0 got=%h exp=0", inst_at(0).pc); end
    total++; if (inst_at(4).pc !== 32'h10) begin bad++; $display("FAIL bp_inst4 got=%h exp=10", inst_at(4).pc); end
    total++; if (inst_at(4).data !== 32'h1000_0010) begin bad++; $display("FAIL bp_inst4_data got=%h exp=10000010", inst_at(4).data); end
  endtask

  task automatic test_redirect_outstanding();
    apply_reset();
    inst_ready = 1'b1;
    resp_hold = 1'b1;
    tick(1);
    imem_ready = 1'b1;
    tick(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    total++; if (imem_valid !== 1'b0) begin bad++; $display("FAIL rd_no_issue got=%b exp=0", imem_valid); end
    tick(1);
    redirect_valid = 1'b0;
    resp_hold = 1'b0;
    @(negedge clk);
    total++; if (imem_addr !== 32'h100 || imem_valid !== 1'b1) begin bad++; $display("FAIL rd_new_cmd got=%b/%h exp=1/100", imem_valid, imem_addr); end
    tick(8);
    total++; if (cmd_at(1) !== 32'h4) begin bad++; $display("FAIL rd_cmd1 got=%h exp=4", cmd_at(1)); end
    total++; if (cmd_at(2) !== 32'h100) begin bad++; $display("FAIL rd_cmd2 got=%h exp=100", cmd_at(2)); end
    total++; if (inst_at(0).pc !== 32'h100) begin bad++; $display("FAIL rd_first_pc got=%h exp=100", inst_at(0).pc); end
    total++; if (inst_at(0).data !== 32'h1000_0100) begin bad++; $display("FAIL rd_first_data got=%h exp=10000100", inst_at(0).data); end
    total++; if (inst_at(1).pc !== 32'h104) begin bad++; $display("FAIL rd_second_pc got=%h exp=104", inst_at(1).pc); end
  endtask

  task automatic test_redirect_resp_pop();
    apply_reset();
    imem_ready = 1'b1;
    inst_ready = 1'b1;
    resp_hold = 1'b1;
    tick(5);
    resp_hold = 1'b0;
    tick(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin bad++; $display("FAIL rrp_setup_head got=%b/%h exp=1/4", inst_valid, inst_pc); end
    total++; if (imem_r_valid !== 1'b1 || imem_valid !== 1'b0) begin bad++; $display("FAIL rrp_setup_resp got=%b/%b exp=1/0", imem_r_valid, imem_valid); end
    tick(1);
    redirect_valid = 1'b0;
    inst_log.delete();
    @(negedge clk);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rrp_flushed got=%b exp=0", inst_valid); end
    total++; if (imem_addr !== 32'h200 || imem_valid !== 1'b1) begin bad++; $display("FAIL rrp_new_cmd got=%b/%h exp=1/200", imem_valid, imem_addr); end
    tick(6);
    total++; if (inst_at(0).pc !== 32'h200) begin bad++; $display("FAIL rrp_first_pc got=%h exp=200", inst_at(0).pc); end
    total++; if (inst_at(0).data !== 32'h1000_0200) begin bad++; $display("FAIL rrp_first_data got=%h exp=10000200", inst_at(0).data); end
  endtask

  task automatic test_error();
    apply_reset();
    imem_ready = 1'b1;
    inst_ready = 1'b1;
    err_en = 1'b1;
    err_addr = 32'h8;
    tick(10);
    @(negedge clk);
    total++; if (cmd_log.size() !== 4) begin bad++; $display("FAIL err_cmd_count got=%0d exp=4", cmd_log.size()); end
    total++; if (imem_valid !== 1'b0) begin bad++; $display("FAIL err_halted_valid got=%b exp=0", imem_valid); end
    total++; if (dbg_state !== S_HALT) begin bad++; $display("FAIL err_state got=%0d exp=%0d", dbg_state, S_HALT); end
    total++; if (inst_log.size() !== 3) begin bad++; $display("FAIL err_inst_count got=%0d exp=3", inst_log.size()); end
    total++; if (inst_at(2).pc !== 32'h8 || inst_at(2).err !== 1'b1) begin bad++; $display("FAIL err_entry got=%h/%b exp=8/1", inst_at(2).pc, inst_at(2).err); end
    total++; if (inst_at(2).data !== 32'h1000_0008) begin bad++; $display("FAIL err_entry_data got=%h exp=10000008", inst_at(2).data); end
    total++; if (inst_at(1).err !== 1'b0) begin bad++; $display("FAIL err_prev_clean got=%b exp=0", inst_at(1).err); end
    tick(1);
    err_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    cmd_log.delete();
    inst_log.delete();
    tick(1);
    redirect_valid = 1'b0;
    tick(6);
    total++; if (cmd_at(0) !== 32'h40) begin bad++; $display("FAIL err_resume_cmd got=%h exp=40", cmd_at(0)); end
    total++; if (inst_at(0).pc !== 32'h40 || inst_at(0).err !== 1'b0) begin bad++; $display("FAIL err_resume_inst got=%h/%b exp=40/0", inst_at(0).pc, inst_at(0).err); end
    total++; if (dbg_state !== S_RUN) begin bad++; $display("FAIL err_resume_state got=%0d exp=%0d", dbg_state, S_RUN); end
  endtask

  task automatic test_wrap_and_reset();
    apply_reset();
    imem_ready = 1'b1;
    inst_ready = 1'b1;
    tick(4);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick(1);
    redirect_valid = 1'b0;
    cmd_log.delete();
    inst_log.delete();
    tick(6);
    total++; if (cmd_at(0) !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_cmd0 got=%h exp=fffffffc", cmd_at(0)); end
    total++; if (cmd_at(1) !== 32'h0) begin bad++; $display("FAIL wrap_cmd1 got=%h exp=0", cmd_at(1)); end
    total++; if (inst_at(0).pc !== 32'hFFFF_FFFC || inst_at(0).data !== 32'h0FFF_FFFC) begin bad++; $display("FAIL wrap_inst0 got=%h/%h exp=fffffffc/0ffffffc", inst_at(0).pc, inst_at(0).data); end
    total++; if (inst_at(1).pc !== 32'h0 || inst_at(1).data !== 32'h1000_0000) begin bad++; $display("FAIL wrap_inst1 got=%h/%h exp=0/10000000", inst_at(1).pc, inst_at(1).data); end
    total++; if (inst_valid !== 1'b1 || imem_valid !== 1'b1) begin bad++; $display("FAIL midrst_active got=%b/%b exp=1/1", inst_valid, imem_valid); end
    rst = 1'b1;
    #1;
    total++; if (imem_valid !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL midrst_valids got=%b/%b exp=0/0", imem_valid, inst_valid); end
    total++; if (dbg_state !== S_RESET) begin bad++; $display("FAIL midrst_state got=%0d exp=%0d", dbg_state, S_RESET); end
    total++; if (imem_addr !== 32'h0 || inst_pc !== 32'h0 || inst_data !== 32'h0) begin bad++; $display("FAIL midrst_values got=%h/%h/%h exp=0/0/0", imem_addr, inst_pc, inst_data); end
    tick(2);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_resp_pop();
    test_error();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
